i2c_write_scheduler: RTL and testbench

- Arbitrates between NUM_REQ requesters (e.g. OTP controller, debug host) for one shared byte-level I2C master engine.
- Per granted request, sequences the engine through a burst: START, device address + W, register address, N data bytes, STOP.
- Collects the ACK/NACK result of each byte and reports done/err to the owning requester.
- Sits between the requesters and the byte engine; runs in the clk_sda domain.

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_write_scheduler_rr_arbiter.sv | 30 +++
 rtl/i2c_write_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_write_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C write scheduler: engine opcodes,
// scheduler states and the byte phase tracked across WRSP.
package i2c_pkg;

    typedef enum logic [1:0] {
        I2C_OP_START = 2'b00,
        I2C_OP_BYTE  = 2'b01,
        I2C_OP_STOP  = 2'b10
    } i2c_op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_START,
        ST_DEV,
        ST_REG,
        ST_DATA,
        ST_WRSP,
        ST_STOP,
        ST_GAP
    } sched_state_e;

    typedef enum logic [1:0] {
        PH_DEV,
        PH_REG,
        PH_DATA
    } phase_e;

    localparam logic I2C_WR = 1'b0;

endpackage

// File: rtl/i2c_write_scheduler_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the
// last winner held in the parent's pointer register.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         idx,
    output logic               any
);

    function automatic int nxt(input int p, input int k);
        return (p + k) % NUM_REQ;
    endfunction

    always_comb begin
        gnt = '0;
        idx = ptr;
        any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!any && req[nxt(int'(ptr), k)]) begin
                any = 1'b1;
                idx = 2'(nxt(int'(ptr), k));
                gnt[nxt(int'(ptr), k)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_write_scheduler.sv
// Shares one byte-level I2C master among several requesters and
// walks each grant through START, dev, reg, data and STOP.
module i2c_write_scheduler
    import i2c_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int LEN_W      = 5,
    parameter int GAP_CYCLES = 10
) (
    input  logic                     clk_sda,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [7*NUM_REQ-1:0]     req_dev_addr,
    input  logic [8*NUM_REQ-1:0]     req_reg_addr,
    input  logic [LEN_W*NUM_REQ-1:0] req_len,
    input  logic [8*NUM_REQ-1:0]     wdata,
    output logic [NUM_REQ-1:0]       wdata_pop,
    output logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       err,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [1:0]               cmd_op,
    output logic [7:0]               cmd_byte,
    input  logic                     rsp_valid,
    input  logic                     rsp_nack,
    output logic                     busy,
    output logic [1:0]               grant_id
);

    localparam int GAP_W =
        (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    sched_state_e state, state_nx;
    phase_e       phase;

    logic [1:0]         ptr, owner;
    logic [6:0]         dev_q;
    logic [7:0]         reg_q;
    logic [LEN_W-1:0]   rem_q;
    logic               err_flag, busy_q;
    logic [GAP_W-1:0]   gap_cnt;

    logic [NUM_REQ-1:0] gnt, own_oh;
    logic [1:0]         win;
    logic               win_any;
    logic [6:0]         sel_dev;
    logic [7:0]         sel_reg, own_byte;
    logic [LEN_W-1:0]   sel_len;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (win),
        .any (win_any)
    );

    // Winner fields for ARB, owner byte lane for DATA.
    always_comb begin
        sel_dev  = '0;
        sel_reg  = '0;
        sel_len  = '0;
        own_oh   = '0;
        own_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_dev = req_dev_addr[7*i +: 7];
                sel_reg = req_reg_addr[8*i +: 8];
                sel_len = req_len[LEN_W*i +: LEN_W];
            end
            if (owner == 2'(i)) begin
                own_oh[i] = 1'b1;
                own_byte  = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_sda or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (|req_valid) state_nx = ST_ARB;
            ST_ARB:   state_nx = win_any ? ST_START : ST_IDLE;
            ST_START: if (cmd_ready) state_nx = ST_DEV;
            ST_DEV:   if (cmd_ready) state_nx = ST_WRSP;
            ST_REG:   if (cmd_ready) state_nx = ST_WRSP;
            ST_DATA:  if (cmd_ready) state_nx = ST_WRSP;
            ST_WRSP: begin
                if (rsp_valid) begin
                    if (rsp_nack)
                        state_nx = ST_STOP;
                    else if (phase == PH_DEV)
                        state_nx = ST_REG;
                    else if (rem_q != '0)
                        state_nx = ST_DATA;
                    else
                        state_nx = ST_STOP;
                end
            end
            ST_STOP:  if (cmd_ready) state_nx = ST_GAP;
            ST_GAP:   if (gap_cnt == '0) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Remaining count is tested before decrement so it never wraps.
    always_ff @(posedge clk_sda or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 2'(NUM_REQ - 1);
            owner    <= '0;
            dev_q    <= '0;
            reg_q    <= '0;
            rem_q    <= '0;
            phase    <= PH_DEV;
            err_flag <= 1'b0;
            busy_q   <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                ST_ARB: if (win_any) begin
                    ptr    <= win;
                    owner  <= win;
                    dev_q  <= sel_dev;
                    reg_q  <= sel_reg;
                    rem_q  <= sel_len;
                    busy_q <= 1'b1;
                end
                ST_DEV: if (cmd_ready) phase <= PH_DEV;
                ST_REG: if (cmd_ready) phase <= PH_REG;
                ST_DATA: if (cmd_ready) begin
                    phase <= PH_DATA;
                    if (rem_q != '0)
                        rem_q <= rem_q - LEN_W'(1);
                end
                ST_WRSP: if (rsp_valid && rsp_nack)
                    err_flag <= 1'b1;
                ST_STOP: if (cmd_ready) begin
                    err_flag <= 1'b0;
                    gap_cnt  <= GAP_W'(GAP_CYCLES - 1);
                end
                ST_GAP: begin
                    if (gap_cnt != '0)
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    else
                        busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        wdata_pop = '0;
        done      = '0;
        err       = '0;
        cmd_valid = 1'b0;
        cmd_op    = I2C_OP_STOP;
        cmd_byte  = '0;
        unique case (state)
            ST_ARB: req_ready = gnt;
            ST_START: begin
                cmd_valid = 1'b1;
                cmd_op    = I2C_OP_START;
            end
            ST_DEV: begin
                cmd_valid = 1'b1;
                cmd_op    = I2C_OP_BYTE;
                cmd_byte  = {dev_q, I2C_WR};
            end
            ST_REG: begin
                cmd_valid = 1'b1;
                cmd_op    = I2C_OP_BYTE;
                cmd_byte  = reg_q;
            end
            ST_DATA: begin
                cmd_valid = 1'b1;
                cmd_op    = I2C_OP_BYTE;
                cmd_byte  = own_byte;
                if (cmd_ready) wdata_pop = own_oh;
            end
            ST_STOP: begin
                cmd_valid = 1'b1;
                cmd_op    = I2C_OP_STOP;
                if (cmd_ready) begin
                    done = own_oh;
                    err  = err_flag ? own_oh : '0;
                end
            end
            default: ;
        endcase
    end

    assign busy     = busy_q;
    assign grant_id = owner;

endmodule

// File: tb/tb_i2c_write_scheduler.sv
// Scoreboard bench: stimulus queues expected commands, pops, grants
// and completions; a forked monitor checks them as the DUT emits them.
module tb_i2c_write_scheduler;

    localparam int NUM_REQ    = 2;
    localparam int LEN_W      = 5;
    localparam int GAP_CYCLES = 10;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_BYTE  = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;

    logic        clk_sda = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [13:0] req_dev_addr;
    logic [15:0] req_reg_addr;
    logic [9:0]  req_len;
    logic [15:0] wdata;
    logic [1:0]  wdata_pop;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_byte;
    logic        rsp_valid;
    logic        rsp_nack;
    logic        busy;
    logic [1:0]  grant_id;

    i2c_write_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .LEN_W      (LEN_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk_sda      (clk_sda),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dev_addr (req_dev_addr),
        .req_reg_addr (req_reg_addr),
        .req_len      (req_len),
        .wdata        (wdata),
        .wdata_pop    (wdata_pop),
        .done         (done),
        .err          (err),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_byte     (cmd_byte),
        .rsp_valid    (rsp_valid),
        .rsp_nack     (rsp_nack),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 clk_sda = ~clk_sda;

    logic [9:0] exp_cmd[$];
    int         exp_pop[$];
    logic [2:0] exp_done[$];
    int         exp_grant[$];
    logic [7:0] wq0[$];
    logic [7:0] wq1[$];
    logic [7:0] dbuf[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int data_pops = 0;

    // engine / monitor shared state
    bit  tie_high = 0;
    int  bp = 0;
    int  stall = 0;
    bit  hs_seen = 0;
    bit  byte_acc = 0;
    bit  acc_nack = 0;
    bit  spur = 0;
    bit  nack_en = 0;
    logic [7:0] nack_val = 8'h00;
    logic [1:0] pop_mask = '0;
    logic [1:0] drop_mask = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic extra(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got unexpected event, required none", name);
    endtask

    task automatic refresh_wdata();
        wdata[7:0]  = (wq0.size() > 0) ? wq0[0] : 8'h00;
        wdata[15:8] = (wq1.size() > 0) ? wq1[0] : 8'h00;
    endtask

    task automatic engine();
        forever begin
            @(posedge clk_sda);
            #1;
            if (!rst_n) begin
                cmd_ready = 0; rsp_valid = 0; rsp_nack = 0;
                stall = 0; byte_acc = 0; spur = 0; hs_seen = 0;
                pop_mask = '0; drop_mask = '0;
                continue;
            end
            rsp_valid = byte_acc || spur;
            rsp_nack  = (byte_acc && acc_nack) || spur;
            byte_acc  = 0;
            spur      = 0;
            req_valid = req_valid & ~drop_mask;
            drop_mask = '0;
            if (pop_mask[0] && wq0.size() > 0) void'(wq0.pop_front());
            if (pop_mask[1] && wq1.size() > 0) void'(wq1.pop_front());
            pop_mask = '0;
            refresh_wdata();
            if (hs_seen) stall = 0;
            hs_seen = 0;
            if (tie_high) cmd_ready = 1;
            else if (cmd_valid) begin
                cmd_ready = (stall >= bp);
                stall++;
            end else cmd_ready = 0;
        end
    endtask

    task automatic monitor();
        bit stalled = 0, arb_seen = 0, waiting = 0, last_byte = 0;
        int arb_cyc = 0, done_cyc = 0, acc_cyc = 0;
        logic [1:0] h_op = '0;
        logic [7:0] h_byte = '0;
        logic [9:0] e;
        logic [2:0] d;
        int id;
        forever begin
            @(negedge clk_sda);
            cyc++;
            if (!rst_n) begin
                stalled = 0; arb_seen = 0; waiting = 0; last_byte = 0;
                continue;
            end
            if (stalled) begin
                check("stall_valid", 32'(cmd_valid), 1);
                check("stall_op", 32'(cmd_op), 32'(h_op));
                check("stall_byte", 32'(cmd_byte), 32'(h_byte));
            end
            stalled = cmd_valid && !cmd_ready;
            h_op = cmd_op;
            h_byte = cmd_byte;
            if (arb_seen && cmd_valid) begin
                check("arb_to_cmd", 32'(cyc - arb_cyc), 1);
                arb_seen = 0;
            end
            if (|req_ready) begin
                if (exp_grant.size() == 0) extra("grant");
                else begin
                    id = exp_grant.pop_front();
                    check("grant", 32'(req_ready), 32'(1 << id));
                end
                if (waiting)
                    check("gap", 32'(cyc - done_cyc), GAP_CYCLES + 2);
                waiting = 0;
                arb_seen = 1;
                arb_cyc = cyc;
                drop_mask = req_ready;
            end
            if (cmd_valid && cmd_ready) begin
                hs_seen = 1;
                if (exp_cmd.size() == 0) extra("cmd");
                else begin
                    e = exp_cmd.pop_front();
                    check("cmd_op", 32'(cmd_op), 32'(e[9:8]));
                    if (e[9:8] == OP_BYTE)
                        check("cmd_byte", 32'(cmd_byte), 32'(e[7:0]));
                end
                if (cmd_op == OP_BYTE) begin
                    byte_acc = 1;
                    acc_nack = nack_en && (cmd_byte == nack_val);
                    if (tie_high && last_byte)
                        check("byte_period", 32'(cyc - acc_cyc), 2);
                end
                last_byte = (cmd_op == OP_BYTE);
                acc_cyc = cyc;
            end
            if (|wdata_pop) begin
                data_pops++;
                pop_mask = wdata_pop;
                if (exp_pop.size() == 0) extra("wdata_pop");
                else begin
                    id = exp_pop.pop_front();
                    check("wdata_pop", 32'(wdata_pop), 32'(1 << id));
                end
            end
            if (|done) begin
                if (exp_done.size() == 0) extra("done");
                else begin
                    d = exp_done.pop_front();
                    check("done", 32'(done), 32'(1 << d[1:0]));
                    check("err", 32'(err),
                          d[2] ? 32'(1 << d[1:0]) : 0);
                end
                done_cyc = cyc;
                waiting = |(req_valid & ~drop_mask);
                spur = 1;
            end
        end
    endtask

    task automatic set_req(input int id, input logic [6:0] dev,
                           input logic [7:0] ra, input int len,
                           input bit nack_dev);
        req_dev_addr[7*id +: 7]         = dev;
        req_reg_addr[8*id +: 8]         = ra;
        req_len[LEN_W*id +: LEN_W]      = LEN_W'(len);
        foreach (dbuf[k]) begin
            if (id == 0) wq0.push_back(dbuf[k]);
            else         wq1.push_back(dbuf[k]);
        end
        refresh_wdata();
        exp_grant.push_back(id);
        exp_cmd.push_back({OP_START, 8'h00});
        exp_cmd.push_back({OP_BYTE, dev, 1'b0});
        if (nack_dev) begin
            exp_cmd.push_back({OP_STOP, 8'h00});
            exp_done.push_back({1'b1, 2'(id)});
            return;
        end
        exp_cmd.push_back({OP_BYTE, ra});
        for (int k = 0; k < len; k++) begin
            exp_cmd.push_back({OP_BYTE, dbuf[k]});
            exp_pop.push_back(id);
        end
        exp_cmd.push_back({OP_STOP, 8'h00});
        exp_done.push_back({1'b0, 2'(id)});
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 0);
        check({tag, "_cmd_op"}, 32'(cmd_op), 32'(OP_STOP));
        check({tag, "_cmd_byte"}, 32'(cmd_byte), 0);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_wdata_pop"}, 32'(wdata_pop), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_grant_id"}, 32'(grant_id), 0);
    endtask

    task automatic drain(input string tag, input int maxc);
        bit ok = 0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(posedge clk_sda);
            #2;
            ok = exp_cmd.size() == 0 && exp_pop.size() == 0 &&
                 exp_done.size() == 0 && exp_grant.size() == 0 &&
                 !busy && req_valid == 2'b00;
        end
        check({tag, "_drain"}, 32'(ok), 1);
    endtask

    initial begin
        bit hit;
        int base;
        rst_n = 0;
        req_valid = '0;
        req_dev_addr = '0;
        req_reg_addr = '0;
        req_len = '0;
        wdata = '0;
        cmd_ready = 0;
        rsp_valid = 0;
        rsp_nack = 0;
        fork
            engine();
            monitor();
        join_none

        // contention: both requesters pending straight out of reset
        dbuf = '{8'h01, 8'h02};
        set_req(0, 7'h0A, 8'h01, 2, 0);
        dbuf = '{8'h03};
        set_req(1, 7'h2B, 8'h02, 1, 0);
        req_valid = 2'b11;
        repeat (3) @(posedge clk_sda);
        #2;
        reset_checks("reset");
        @(negedge clk_sda);
        rst_n = 1;
        hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(posedge clk_sda);
            #2;
            hit = busy && grant_id == 2'd1;
        end
        check("wait_grant1", 32'(hit), 1);
        dbuf = '{8'h04};
        set_req(0, 7'h50, 8'h03, 1, 0);
        req_valid[0] = 1'b1;
        drain("contention", 2000);

        // single long write, engine always ready
        tie_high = 1;
        dbuf = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF,
                 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF};
        set_req(0, 7'h0A, 8'h12, 11, 0);
        req_valid[0] = 1'b1;
        drain("single", 2000);

        // NACK on the device address byte
        tie_high = 0;
        nack_en = 1;
        nack_val = 8'h66;
        dbuf = '{8'h77, 8'h78};
        set_req(1, 7'h33, 8'h44, 2, 1);
        req_valid[1] = 1'b1;
        drain("nack", 2000);
        nack_en = 0;
        wq1.delete();
        refresh_wdata();

        // address-only write
        dbuf.delete();
        set_req(0, 7'h0A, 8'h05, 0, 0);
        req_valid[0] = 1'b1;
        drain("len0", 2000);

        // backpressure on every command
        bp = 5;
        dbuf = '{8'h11, 8'h22, 8'h33};
        set_req(1, 7'h21, 8'h40, 3, 0);
        req_valid[1] = 1'b1;
        drain("backpressure", 4000);
        bp = 0;

        // reset while the third data byte is on the bus
        tie_high = 1;
        base = data_pops;
        dbuf = '{8'h90, 8'h91, 8'h92, 8'h93, 8'h94};
        set_req(0, 7'h0A, 8'h30, 5, 0);
        req_valid[0] = 1'b1;
        hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(posedge clk_sda);
            #2;
            hit = data_pops == base + 2 && cmd_valid &&
                  cmd_op == OP_BYTE;
        end
        check("wait_data3", 32'(hit), 1);
        rst_n = 0;
        #1;
        reset_checks("midreset");
        exp_cmd.delete();
        exp_pop.delete();
        exp_done.delete();
        exp_grant.delete();
        wq0.delete();
        dbuf = '{8'hA5};
        set_req(0, 7'h0A, 8'h31, 1, 0);
        req_valid[0] = 1'b1;
        @(negedge clk_sda);
        rst_n = 1;
        drain("after_reset", 2000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
